ctrl_unit: RTL and testbench

- Instruction-sequencing controller; drives every control input of the CPU data path and consumes its pc_out and en_out.
- Fetches a 16-bit instruction word addressed by pc_out, decodes it, and launches one data-path operation.
- Waits for completion, commits the register write, then advances or loads the PC.
- Sits between the instruction ROM and the data path.

---
 rtl/ctrl_unit.sv | 153 +++++++++++++++
 tb/tb_ctrl_unit.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_unit.sv
// Instruction-sequencing controller: fetches a 16-bit word at the PC, launches one
// data-path operation, waits for completion, writes back, then advances or loads the PC.
module ctrl_unit #(
  parameter int DWIDTH  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_in,
  input  logic [DWIDTH-1:0] ins,
  input  logic              ins_valid,
  input  logic              dp_done,
  output logic              dp_en,
  output logic              en_pc_pulse,
  output logic [1:0]        pc_ctrl,
  output logic [7:0]        offset_addr,
  output logic [7:0]        offset,
  output logic [1:0]        rd,
  output logic [1:0]        rs,
  output logic              alu_in_sel,
  output logic [2:0]        alu_func,
  output logic [3:0]        reg_en,
  output logic              halted,
  output logic              err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_EXEC, S_WAIT, S_WB, S_NEXT, S_HALT, S_ERR
  } state_t;

  typedef enum logic [2:0] {K_NOP, K_ALU, K_JMP, K_HALT, K_ILL} kind_t;

  state_t            state, state_next;
  logic [DWIDTH-1:0] ir;
  logic [CW-1:0]     wait_cnt;
  kind_t             ins_kind;
  logic              jump;
  logic [3:0]        ir_alu;

  function automatic kind_t op_kind(input logic [3:0] op);
    kind_t k;
    case (op)
      4'h0:                       k = K_NOP;
      4'h1, 4'h2, 4'h3, 4'h4, 4'h5,
      4'h6, 4'h7, 4'h8, 4'h9:     k = K_ALU;
      4'hA:                       k = K_JMP;
      4'hF:                       k = K_HALT;
      default:                    k = K_ILL;
    endcase
    return k;
  endfunction

  // Returns {alu_in_sel, alu_func}; non-ALU opcodes decode to zero.
  function automatic logic [3:0] alu_ctl(input logic [3:0] op);
    logic [3:0] c;
    case (op)
      4'h1:    c = {1'b0, 3'b101};
      4'h2:    c = {1'b1, 3'b101};
      4'h3:    c = {1'b0, 3'b000};
      4'h4:    c = {1'b1, 3'b000};
      4'h5:    c = {1'b0, 3'b001};
      4'h6:    c = {1'b1, 3'b001};
      4'h7:    c = {1'b0, 3'b010};
      4'h8:    c = {1'b0, 3'b011};
      4'h9:    c = {1'b0, 3'b100};
      default: c = 4'b0000;
    endcase
    return c;
  endfunction

  assign ins_kind = op_kind(ins[15:12]);
  assign jump     = (op_kind(ir[15:12]) == K_JMP);
  assign ir_alu   = alu_ctl(ir[15:12]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Operand fields come straight from the instruction register, so they stay
  // stable from EXEC through WB and only change on the next fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir       <= '0;
      wait_cnt <= '0;
    end else begin
      if (state == S_FETCH && ins_valid) begin
        ir <= ins;
      end
      if (state == S_EXEC) begin
        wait_cnt <= '0;
      end else if (state == S_WAIT) begin
        wait_cnt <= wait_cnt + CW'(1);
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (en_in) state_next = S_FETCH;
      S_FETCH: begin
        if (ins_valid) begin
          case (ins_kind)
            K_NOP, K_JMP: state_next = S_NEXT;
            K_HALT:       state_next = S_HALT;
            K_ILL:        state_next = S_ERR;
            default:      state_next = S_EXEC;
          endcase
        end
      end
      S_EXEC:  state_next = S_WAIT;
      // A completion on the last permitted cycle beats the timeout.
      S_WAIT: begin
        if (dp_done) begin
          state_next = S_WB;
        end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
          state_next = S_ERR;
        end
      end
      S_WB:    state_next = S_NEXT;
      S_NEXT:  state_next = S_FETCH;
      S_HALT:  state_next = S_HALT;
      S_ERR:   state_next = S_ERR;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    dp_en       = (state == S_EXEC);
    reg_en      = (state == S_WB) ? (4'b0001 << ir[11:10]) : 4'b0000;
    en_pc_pulse = (state == S_NEXT);
    pc_ctrl     = 2'b00;
    offset_addr = 8'h00;
    if (state == S_NEXT) begin
      pc_ctrl     = jump ? 2'b10 : 2'b01;
      offset_addr = jump ? ir[7:0] : 8'h00;
    end
    rd         = ir[11:10];
    rs         = ir[9:8];
    offset     = ir[7:0];
    alu_in_sel = ir_alu[3];
    alu_func   = ir_alu[2:0];
    halted     = (state == S_HALT);
    err        = (state == S_ERR);
  end

endmodule

// File: tb/tb_ctrl_unit.sv
// Randomised bench for ctrl_unit: a driver plays ROM and data path and queues the
// expected strobes with their cycle numbers; a negedge monitor pops and compares.
module tb_ctrl_unit;

  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en_in = 1'b0;
  logic [15:0] ins = 16'h0;
  logic        ins_valid = 1'b0;
  logic        dp_done = 1'b0;
  logic        dp_en, en_pc_pulse, alu_in_sel, halted, err;
  logic [1:0]  pc_ctrl, rd, rs;
  logic [7:0]  offset_addr, offset;
  logic [2:0]  alu_func;
  logic [3:0]  reg_en;

  ctrl_unit #(.DWIDTH(16), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .en_in(en_in), .ins(ins), .ins_valid(ins_valid),
    .dp_done(dp_done), .dp_en(dp_en), .en_pc_pulse(en_pc_pulse), .pc_ctrl(pc_ctrl),
    .offset_addr(offset_addr), .offset(offset), .rd(rd), .rs(rs),
    .alu_in_sel(alu_in_sel), .alu_func(alu_func), .reg_en(reg_en),
    .halted(halted), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // kind: 0 launch, 1 write-back, 2 pc update, 3 error, 4 halt
  typedef struct {
    int          kind;
    int          at;
    logic [15:0] w;
  } ev_t;
  ev_t q[$];

  // Reference decode, straight from the opcode table.
  function automatic int cls(input logic [15:0] w);
    int op = int'(w[15:12]);
    if (op == 0) return 0;             // NOP
    if (op >= 1 && op <= 9) return 1;  // ALU
    if (op == 10) return 2;            // JMP
    if (op == 15) return 3;            // HALT
    return 4;                          // illegal
  endfunction

  function automatic logic [3:0] ref_ctl(input logic [15:0] w);
    logic [2:0] fn [16];
    logic       im [16];
    for (int i = 0; i < 16; i++) begin fn[i] = 3'd0; im[i] = 1'b0; end
    fn[1] = 3'd5; fn[2] = 3'd5; fn[3] = 3'd0; fn[4] = 3'd0; fn[5] = 3'd1;
    fn[6] = 3'd1; fn[7] = 3'd2; fn[8] = 3'd3; fn[9] = 3'd4;
    im[2] = 1'b1; im[4] = 1'b1; im[6] = 1'b1;
    return {im[w[15:12]], fn[w[15:12]]};
  endfunction

  logic err_p = 1'b0, halt_p = 1'b0;

  always @(negedge clk) begin
    int   kind;
    ev_t  e;
    logic [19:0] got, exp_v;
    if (!rst_n) begin
      err_p  = 1'b0;
      halt_p = 1'b0;
    end else begin
      checks++;
      if (int'(dp_en) + int'(reg_en != 4'b0) + int'(en_pc_pulse) > 1) begin
        errors++;
        $display("FAIL exclusive cyc=%0d dp_en=%b reg_en=%b en_pc_pulse=%b (need at most one)",
                 cyc, dp_en, reg_en, en_pc_pulse);
      end
      checks++;
      if (!en_pc_pulse && pc_ctrl != 2'b00) begin
        errors++;
        $display("FAIL pc_hold cyc=%0d pc_ctrl=%b required 00", cyc, pc_ctrl);
      end
      if ((err_p && !err) || (halt_p && !halted)) begin
        checks++;
        errors++;
        $display("FAIL sticky cyc=%0d err=%b halted=%b required held at 1", cyc, err, halted);
      end
      while (q.size() > 0 && q[0].at < cyc) begin
        checks++;
        errors++;
        $display("FAIL missed cyc=%0d kind=%0d word=%h due at cycle %0d, not seen",
                 cyc, q[0].kind, q[0].w, q[0].at);
        void'(q.pop_front());
      end
      kind = -1;
      if (dp_en) kind = 0;
      else if (reg_en != 4'b0) kind = 1;
      else if (en_pc_pulse) kind = 2;
      else if (err && !err_p) kind = 3;
      else if (halted && !halt_p) kind = 4;
      if (kind >= 0) begin
        checks++;
        if (q.size() == 0 || q[0].at != cyc || q[0].kind != kind) begin
          errors++;
          $display("FAIL unexpected cyc=%0d kind=%0d, required kind=%0d at cycle %0d",
                   cyc, kind, (q.size() > 0) ? q[0].kind : -1, (q.size() > 0) ? q[0].at : -1);
        end else begin
          e = q.pop_front();
          if (kind <= 1) begin
            got   = {rd, rs, offset, alu_in_sel, alu_func, reg_en};
            exp_v = {e.w[11:10], e.w[9:8], e.w[7:0], ref_ctl(e.w),
                     (kind == 1) ? (4'b0001 << e.w[11:10]) : 4'b0000};
          end else if (kind == 2 && cls(e.w) == 2) begin
            got   = {10'd0, pc_ctrl, offset_addr};
            exp_v = {10'd0, 2'b10, e.w[7:0]};
          end else if (kind == 2) begin
            got   = {18'd0, pc_ctrl};
            exp_v = {18'd0, 2'b01};
          end else begin
            got   = {18'd0, err, halted};
            exp_v = {18'd0, kind == 3, kind == 4};
          end
          if (got !== exp_v) begin
            errors++;
            $display("FAIL fields cyc=%0d kind=%0d word=%h got=%h required=%h",
                     cyc, kind, e.w, got, exp_v);
          end else begin
            $display("cyc=%0d kind=%0d word=%h ok", cyc, kind, e.w);
          end
        end
      end
      err_p  = err;
      halt_p = halted;
    end
  end

  function automatic logic nz();
    return ($urandom_range(0, 3) == 0);
  endfunction

  task automatic step(input logic [15:0] w, input logic v, input logic d, input logic e);
    ins = w; ins_valid = v; dp_done = d; en_in = e;
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string name);
    logic [37:0] o;
    o = {dp_en, en_pc_pulse, pc_ctrl, offset_addr, offset, rd, rs, alu_in_sel,
         alu_func, reg_en, halted, err};
    checks++;
    if (o !== '0) begin
      errors++;
      $display("FAIL %s outputs=%h required all zero", name, o);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_zero("reset");
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic start();
    int idle = $urandom_range(1, 3);
    for (int i = 0; i < idle; i++) step(16'($urandom), nz(), nz(), 1'b0);
    step(16'($urandom), 1'b0, nz(), 1'b1);
  endtask

  // Entered in the first FETCH cycle; n = 0 means the data path never answers.
  task automatic run_ins(input logic [15:0] w, input int d, input int n);
    int   f = cyc;
    int   c = cls(w);
    ev_t  e;
    e.w = w;
    if (c == 1) begin
      e.kind = 0; e.at = f + d + 1; q.push_back(e);
      if (n > 0) begin
        e.kind = 1; e.at = f + d + n + 2; q.push_back(e);
        e.kind = 2; e.at = f + d + n + 3; q.push_back(e);
      end else begin
        e.kind = 3; e.at = f + d + 2 + TIMEOUT; q.push_back(e);
      end
    end else if (c == 0 || c == 2) begin
      e.kind = 2; e.at = f + d + 1; q.push_back(e);
    end else begin
      e.kind = (c == 3) ? 4 : 3; e.at = f + d + 1; q.push_back(e);
    end
    for (int i = 0; i < d; i++) step(16'($urandom), 1'b0, nz(), nz());
    step(w, 1'b1, nz(), nz());
    if (c == 1) begin
      step(16'($urandom), nz(), nz(), nz());
      if (n > 0) begin
        for (int k = 1; k <= n; k++) step(16'($urandom), nz(), k == n, nz());
        step(16'($urandom), nz(), nz(), nz());
        step(16'($urandom), nz(), nz(), nz());
      end else begin
        for (int k = 0; k < TIMEOUT; k++) step(16'($urandom), nz(), 1'b0, nz());
      end
    end else if (c == 0 || c == 2) begin
      step(16'($urandom), nz(), nz(), nz());
    end
  endtask

  task automatic finish_terminal(input logic want_err);
    for (int i = 0; i < 20; i++) step(16'($urandom), nz(), nz(), nz());
    checks++;
    if ({err, halted} !== {want_err, !want_err}) begin
      errors++;
      $display("FAIL terminal err=%b halted=%b required err=%b halted=%b",
               err, halted, want_err, !want_err);
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required 0", q.size());
    end
  endtask

  function automatic logic [15:0] rnd_alu();
    return {4'($urandom_range(1, 9)), 12'($urandom)};
  endfunction

  task automatic mid_wait_reset();
    int  f = cyc;
    int  d = $urandom_range(0, 2);
    ev_t e;
    logic [15:0] w = rnd_alu();
    e.kind = 0; e.at = f + d + 1; e.w = w; q.push_back(e);
    for (int i = 0; i < d; i++) step(16'($urandom), 1'b0, 1'b0, 1'b0);
    step(w, 1'b1, 1'b0, 1'b0);
    step(16'h0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) step(16'h0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    start();
    run_ins(rnd_alu(), 0, 2);
    run_ins(16'hF000, 0, 0);
    finish_terminal(1'b0);
  endtask

  initial begin
    #1;
    check_zero("power_on");
    do_reset();

    // Directed program: MOVI, ADD, boundary wait, JMP, NOP, HALT.
    start();
    run_ins(16'h2405, 3, 2);
    run_ins(16'h3600, 0, 1);
    run_ins(16'h3600, 1, 3);
    run_ins(16'h1B00, 0, TIMEOUT);
    run_ins(16'hA03C, 1, 0);
    run_ins(16'h0000, 0, 0);
    run_ins(16'hF000, 0, 0);
    finish_terminal(1'b0);

    do_reset();
    start();
    run_ins(16'h4307, 0, 4);
    run_ins(16'h5100, 0, 0);
    finish_terminal(1'b1);

    do_reset();
    start();
    run_ins(16'hB000, 2, 0);
    finish_terminal(1'b1);

    do_reset();
    start();
    mid_wait_reset();

    for (int ep = 0; ep < 10; ep++) begin
      int k = $urandom_range(3, 8);
      int t = $urandom_range(0, 3);
      do_reset();
      start();
      for (int i = 0; i < k; i++) begin
        int r = $urandom_range(0, 11);
        int n = ($urandom_range(0, 4) == 0) ? TIMEOUT : $urandom_range(1, TIMEOUT);
        logic [15:0] w;
        if (r == 9) w = {4'h0, 12'($urandom)};
        else if (r == 10) w = {4'hA, 12'($urandom)};
        else w = rnd_alu();
        run_ins(w, $urandom_range(0, 3), n);
      end
      case (t)
        0: begin run_ins({4'hF, 12'($urandom)}, $urandom_range(0, 3), 0); finish_terminal(1'b0); end
        1: begin run_ins({4'($urandom_range(11, 14)), 12'($urandom)}, $urandom_range(0, 3), 0);
                 finish_terminal(1'b1); end
        2: begin run_ins(rnd_alu(), $urandom_range(0, 3), 0); finish_terminal(1'b1); end
        default: mid_wait_reset();
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
